handshake_arbiter: RTL and testbench
====================================

Name: handshake_arbiter

Overview:
- Shares one downstream request/accept/done handshake unit among N_REQ requesters.
- Selects one requester round-robin and routes its request to the shared unit while the requester holds a one-hot grant.
- Returns a per-requester done pulse when the shared unit reports done.
- A watchdog aborts transactions that stall.

Parameters:
N_REQ, 4, number of requesters (>=2)
TIMEOUT_CYC, 64, max cycles spent in GRANT+WAIT_DONE per transaction; 0 disables watchdog
IDX_W, $clog2(N_REQ), width of index outputs (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req  in  N_REQ  per-requester level request; held until that requester sees accept
grant  out  N_REQ  one-hot grant, registered
grant_idx  out  IDX_W  index of current/last granted requester
done_out  out  N_REQ  one-cycle done pulse to the granted requester
dn_request  out  1  request to shared unit
dn_accept  in  1  accept from shared unit
dn_done  in  1  one-cycle done from shared unit
busy  out  1  high in any state other than IDLE
timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Reset values: state=IDLE, ptr=0, grant=0, grant_idx=0, done_out=0, timeout_err=0, busy=0, dn_request=0, acc_seen=0, wdog=0.
- States: IDLE, GRANT, WAIT_DONE, RELEASE, ABORT.
- IDLE:
  - If req != 0, winner = first set bit searching ptr, ptr+1, ..., wrapping mod N_REQ.
  - Register sel=winner, set grant[sel], clear acc_seen and wdog, go to GRANT.
  - Latency: req at cycle 0 -> grant at cycle 1.
- GRANT:
  - dn_request = req[sel] (combinational mux gated by state). All other requesters are ignored.
  - dn_accept high sets acc_seen.
  - If req[sel]==0 and acc_seen (or dn_accept in the same cycle) -> WAIT_DONE.
  - If req[sel]==0 and no accept was ever seen (withdrawal) -> IDLE: grant cleared, no done_out, ptr=sel+1.
- WAIT_DONE:
  - dn_request=0; grant held.
  - dn_done -> RELEASE.
  - dn_done arriving in GRANT is ignored.
- RELEASE: done_out[sel]=1 for exactly one cycle, grant[sel] still high; ptr=(sel+1) mod N_REQ; next state IDLE, grant cleared.
- Throughput: a pending requester is granted on the cycle after RELEASE plus one IDLE cycle, i.e. minimum one idle cycle between grants.
- Watchdog:
  - wdog increments every cycle in GRANT or WAIT_DONE.
  - If TIMEOUT_CYC!=0 and wdog==TIMEOUT_CYC-1 with no exit condition that cycle -> ABORT.
  - ABORT: timeout_err=1 for one cycle, dn_request=0, no done_out, ptr=sel+1, then IDLE.
  - A normal exit condition wins over timeout in the same cycle.
- Fairness: ptr advances only after a granted transaction ends (RELEASE, ABORT, or withdrawal). A requester waits at most N_REQ-1 transactions.
- Simultaneous events: new req edges during a transaction are only sampled in IDLE. req of non-granted requesters may change freely.
- Reset mid-operation: returns to reset values the next edge. No done_out or timeout_err is emitted, and dn_request drops immediately (state=IDLE).
- grant and done_out are always one-hot or zero; never both asserted to different indices.

Test Plan:
1. Single requester: req=4'b0010 at cycle 0, dn_accept at cycle 3, req drops at cycle 4, dn_done at cycle 7 -> grant=4'b0010 from cycle 1, dn_request high cycles 1-3, done_out=4'b0010 only at cycle 8, IDLE at cycle 9, ptr=2.
2. Round-robin: req=4'b1111 held, each transaction completed -> grant order 0,1,2,3,0; grant_idx matches; no requester granted twice before all others.
3. Wrap and skip: ptr=3, req=4'b0101 -> grant index 0 next, then 2.
4. Withdrawal: grant to 1, req[1] drops before any dn_accept -> IDLE next cycle, done_out stays 0, next grant searches from 2.
5. Watchdog: TIMEOUT_CYC=8, accept given, dn_done never arrives -> timeout_err pulses exactly once, 8 cycles after grant; done_out=0; busy low afterwards. With TIMEOUT_CYC=0 the arbiter stays in WAIT_DONE indefinitely.
6. Reset in WAIT_DONE: rst=1 for 1 cycle -> all outputs 0 next cycle, ptr=0; a later dn_done pulse is ignored.

Source files
------------

// File: rtl/handshake_arbiter.sv
// Round-robin arbiter sharing one downstream request/accept/done unit among N_REQ requesters,
// with a per-transaction watchdog that aborts stalled transactions.
module handshake_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned IDX_W       = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] done_out,
  output logic             dn_request,
  input  logic             dn_accept,
  input  logic             dn_done,
  output logic             busy,
  output logic             timeout_err
);

  localparam int unsigned WdogW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StWaitDone,
    StRelease,
    StAbort
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             acc_seen_q, acc_seen_d;
  logic [WdogW-1:0] wdog_q, wdog_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand_idx;
  int unsigned      cand;
  logic             wdog_hit;

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] idx);
    if (32'(idx) == N_REQ - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // First set request searching from ptr upward, wrapping modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    acc_seen_d = acc_seen_q;
    wdog_d     = wdog_q;
    wdog_hit   = (TIMEOUT_CYC != 0) && (wdog_q == WdogLast);

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          sel_d      = win_idx;
          grant_d    = onehot(win_idx);
          acc_seen_d = 1'b0;
          wdog_d     = '0;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        wdog_d = wdog_q + 1'b1;
        if (dn_accept) begin
          acc_seen_d = 1'b1;
        end
        // Normal exit (handoff or withdrawal) takes priority over the watchdog.
        if (!req[sel_q]) begin
          if (acc_seen_q || dn_accept) begin
            state_d = StWaitDone;
          end else begin
            state_d = StIdle;
            grant_d = '0;
            ptr_d   = inc_idx(sel_q);
          end
        end else if (wdog_hit) begin
          state_d = StAbort;
          grant_d = '0;
        end
      end
      StWaitDone: begin
        wdog_d = wdog_q + 1'b1;
        if (dn_done) begin
          state_d = StRelease;
        end else if (wdog_hit) begin
          state_d = StAbort;
          grant_d = '0;
        end
      end
      StRelease: begin
        state_d = StIdle;
        grant_d = '0;
        ptr_d   = inc_idx(sel_q);
      end
      StAbort: begin
        state_d = StIdle;
        ptr_d   = inc_idx(sel_q);
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      ptr_q      <= '0;
      grant_q    <= '0;
      acc_seen_q <= 1'b0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      acc_seen_q <= acc_seen_d;
      wdog_q     <= wdog_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = sel_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = (state_q == StAbort);
  assign done_out    = (state_q == StRelease) ? grant_q : '0;
  assign dn_request  = (state_q == StGrant) && req[sel_q];

endmodule

// File: tb/tb_handshake_arbiter.sv
// Scoreboard bench for handshake_arbiter: directed transactions push expected grant/done/timeout
// events; a negedge monitor pops and compares them as the DUT produces them.
module tb_handshake_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic [3:0] done_out;
  logic       dn_request;
  logic       dn_accept = 1'b0;
  logic       dn_done = 1'b0;
  logic       busy;
  logic       timeout_err;

  // Second instance with the watchdog disabled.
  logic [3:0] req2 = '0;
  logic [3:0] grant2;
  logic [1:0] grant_idx2;
  logic [3:0] done_out2;
  logic       dn_request2;
  logic       dn_accept2 = 1'b0;
  logic       busy2;
  logic       timeout_err2;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int         kind;  // 0 grant, 1 done, 2 timeout
    logic [3:0] val;
    logic [1:0] idx;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] prev_grant = '0;

  always #5 clk = ~clk;

  handshake_arbiter #(.N_REQ(4), .TIMEOUT_CYC(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .done_out   (done_out),
    .dn_request (dn_request),
    .dn_accept  (dn_accept),
    .dn_done    (dn_done),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  handshake_arbiter #(.N_REQ(4), .TIMEOUT_CYC(0)) dut_nt (
    .clk        (clk),
    .rst        (rst),
    .req        (req2),
    .grant      (grant2),
    .grant_idx  (grant_idx2),
    .done_out   (done_out2),
    .dn_request (dn_request2),
    .dn_accept  (dn_accept2),
    .dn_done    (1'b0),
    .busy       (busy2),
    .timeout_err(timeout_err2)
  );

  task automatic push(input int kind, input logic [3:0] val, input logic [1:0] idx);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  task automatic check_evt(input int kind, input logic [3:0] val, input logic [1:0] idx);
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got kind=%0d val=%b idx=%0d, expected none", kind, val, idx);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== val || e.idx !== idx) begin
        miscompares++;
        $display("FAIL event: got kind=%0d val=%b idx=%0d, expected kind=%0d val=%b idx=%0d",
                 kind, val, idx, e.kind, e.val, e.idx);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (grant != 4'b0 && grant != prev_grant) check_evt(0, grant, grant_idx);
      if (done_out != 4'b0) check_evt(1, done_out, grant_idx);
      if (timeout_err) check_evt(2, 4'b0, grant_idx);
    end
    prev_grant <= grant;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    req2 = '0;
    dn_accept = 1'b0;
    dn_accept2 = 1'b0;
    dn_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (grant != 4'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL grant_wait: got no grant in 20 cycles, expected a grant");
    end
  endtask

  // One complete transaction for whichever requester is granted; ends in an IDLE cycle.
  task automatic txn();
    logic [3:0] g;
    bit         ok;
    wait_grant(ok);
    if (ok) begin
      g = grant;
      dn_accept = 1'b1;
      tick();
      dn_accept = 1'b0;
      req = req & ~g;
      tick();
      tick();
      dn_done = 1'b1;
      tick();
      dn_done = 1'b0;
      tick();
    end
  endtask

  initial begin
    bit ok;
    int first;
    int pulses;
    int dones;
    int nt_err;
    int nt_idle;

    do_reset();
    settle();
    chk("reset_grant", grant, 4'b0);
    chk("reset_idx", grant_idx, 2'd0);
    chk("reset_done", done_out, 4'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_terr", timeout_err, 1'b0);
    chk("reset_dnreq", dn_request, 1'b0);
    tick();

    // Single requester with exact cycle timing.
    req = 4'b0010;
    push(0, 4'b0010, 2'd1);
    tick();                                      // cycle 1
    settle();
    chk("t1_grant_c1", grant, 4'b0010);
    chk("t1_dnreq_c1", dn_request, 1'b1);
    tick();                                      // cycle 2
    tick();                                      // cycle 3
    dn_accept = 1'b1;
    settle();
    chk("t1_dnreq_c3", dn_request, 1'b1);
    tick();                                      // cycle 4
    dn_accept = 1'b0;
    req = 4'b0000;
    settle();
    chk("t1_dnreq_c4", dn_request, 1'b0);
    tick();                                      // cycle 5
    settle();
    chk("t1_busy_c5", busy, 1'b1);
    tick();                                      // cycle 6
    tick();                                      // cycle 7
    dn_done = 1'b1;
    push(1, 4'b0010, 2'd1);
    settle();
    chk("t1_done_c7", done_out, 4'b0);
    tick();                                      // cycle 8
    dn_done = 1'b0;
    settle();
    chk("t1_done_c8", done_out, 4'b0010);
    chk("t1_grant_c8", grant, 4'b0010);
    tick();                                      // cycle 9
    settle();
    chk("t1_done_c9", done_out, 4'b0);
    chk("t1_grant_c9", grant, 4'b0);
    chk("t1_busy_c9", busy, 1'b0);

    // Round-robin with all requesters active.
    do_reset();
    req = 4'b1111;
    push(0, 4'b0001, 2'd0); push(1, 4'b0001, 2'd0);
    push(0, 4'b0010, 2'd1); push(1, 4'b0010, 2'd1);
    push(0, 4'b0100, 2'd2); push(1, 4'b0100, 2'd2);
    push(0, 4'b1000, 2'd3); push(1, 4'b1000, 2'd3);
    push(0, 4'b0001, 2'd0); push(1, 4'b0001, 2'd0);
    for (int n = 0; n < 5; n++) begin
      txn();
      if (n < 4) req = 4'b1111;
      else req = 4'b0000;
    end

    // Wrap and skip: ptr brought to 3, then 0101 -> 0 then 2.
    do_reset();
    req = 4'b0100;
    push(0, 4'b0100, 2'd2); push(1, 4'b0100, 2'd2);
    txn();
    req = 4'b0101;
    push(0, 4'b0001, 2'd0); push(1, 4'b0001, 2'd0);
    push(0, 4'b0100, 2'd2); push(1, 4'b0100, 2'd2);
    txn();
    txn();

    // Withdrawal before accept; next search starts at 2.
    do_reset();
    req = 4'b0010;
    push(0, 4'b0010, 2'd1);
    wait_grant(ok);
    req = 4'b1001;
    settle();
    chk("t4_dnreq", dn_request, 1'b0);
    tick();
    push(0, 4'b1000, 2'd3); push(1, 4'b1000, 2'd3);
    push(0, 4'b0001, 2'd0); push(1, 4'b0001, 2'd0);
    settle();
    chk("t4_grant_idle", grant, 4'b0);
    chk("t4_busy_idle", busy, 1'b0);
    chk("t4_done_idle", done_out, 4'b0);
    tick();
    txn();
    txn();

    // Watchdog abort 8 cycles after grant.
    do_reset();
    req = 4'b0100;
    push(0, 4'b0100, 2'd2);
    push(2, 4'b0000, 2'd2);
    wait_grant(ok);
    dn_accept = 1'b1;
    req = 4'b0000;
    first = -1;
    pulses = 0;
    dones = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      dn_accept = 1'b0;
      if (timeout_err) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (done_out != 4'b0) dones++;
    end
    chk("t5_terr_cycle", first, 8);
    chk("t5_terr_pulses", pulses, 1);
    chk("t5_no_done", dones, 0);
    chk("t5_busy_after", busy, 1'b0);

    // Watchdog disabled: stays in WAIT_DONE.
    do_reset();
    req2 = 4'b0001;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (grant2 != 4'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("t5b_grant_seen", ok, 1'b1);
    dn_accept2 = 1'b1;
    req2 = 4'b0000;
    tick();
    dn_accept2 = 1'b0;
    nt_err = 0;
    nt_idle = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (timeout_err2) nt_err++;
      if (!busy2) nt_idle++;
    end
    chk("t5b_no_terr", nt_err, 0);
    chk("t5b_stays_busy", nt_idle, 0);
    chk("t5b_grant_held", grant2, 4'b0001);

    // Reset while waiting for done.
    do_reset();
    req = 4'b0100;
    push(0, 4'b0100, 2'd2);
    wait_grant(ok);
    dn_accept = 1'b1;
    req = 4'b0000;
    tick();
    dn_accept = 1'b0;
    tick();
    tick();
    chk("t6_busy_pre", busy, 1'b1);
    chk("t6_idx_pre", grant_idx, 2'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("t6_grant", grant, 4'b0);
    chk("t6_idx", grant_idx, 2'd0);
    chk("t6_done", done_out, 4'b0);
    chk("t6_terr", timeout_err, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_dnreq", dn_request, 1'b0);
    tick();
    dn_done = 1'b1;
    tick();
    dn_done = 1'b0;
    settle();
    chk("t6_late_done", done_out, 4'b0);
    tick();
    settle();
    chk("t6_late_busy", busy, 1'b0);
    tick();
    req = 4'b1111;
    push(0, 4'b0001, 2'd0); push(1, 4'b0001, 2'd0);
    txn();
    req = 4'b0000;

    tick();
    tick();
    tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
